// File: rtl/riscv_pkg.sv
// ============================================================================
// riscv_pkg
// Shared RISC-V types: immediate format codes, encoder FSM states, XLEN.
// Rev 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_U = 3'b001,
        IMM_S = 3'b010,
        IMM_B = 3'b011,
        IMM_J = 3'b100
    } imm_src_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } enc_state_e;

endpackage

`default_nettype wire

// File: rtl/imm_field_pack.sv
// ============================================================================
// imm_field_pack
// Scatters an immediate into the instruction fields of the selected format
// and flags values that the format cannot represent.
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_field_pack
    import riscv_pkg::*;
(
    input  logic [2:0]      i_imm_src,
    input  logic [XLEN-1:0] i_base,
    input  logic [XLEN-1:0] i_imm,
    output logic [XLEN-1:0] o_instr,
    output logic            o_range_err
);

    // Sign-extension checks: every bit above the field's sign bit must match it.
    logic w_sext_11;
    logic w_sext_12;
    logic w_sext_20;

    assign w_sext_11 = (&i_imm[31:11]) | ~(|i_imm[31:11]);
    assign w_sext_12 = (&i_imm[31:12]) | ~(|i_imm[31:12]);
    assign w_sext_20 = (&i_imm[31:20]) | ~(|i_imm[31:20]);

    always_comb begin
        o_instr     = i_base;
        o_range_err = 1'b1;
        case (imm_src_e'(i_imm_src))
            IMM_I: begin
                o_instr[31:20] = i_imm[11:0];
                o_range_err    = ~w_sext_11;
            end
            IMM_U: begin
                o_instr[31:12] = i_imm[31:12];
                o_range_err    = |i_imm[11:0];
            end
            IMM_S: begin
                o_instr[31:25] = i_imm[11:5];
                o_instr[11:7]  = i_imm[4:0];
                o_range_err    = ~w_sext_11;
            end
            IMM_B: begin
                o_instr[31]    = i_imm[12];
                o_instr[30:25] = i_imm[10:5];
                o_instr[11:8]  = i_imm[4:1];
                o_instr[7]     = i_imm[11];
                o_range_err    = ~w_sext_12 | i_imm[0];
            end
            IMM_J: begin
                o_instr[31]    = i_imm[20];
                o_instr[30:21] = i_imm[10:1];
                o_instr[20]    = i_imm[11];
                o_instr[19:12] = i_imm[19:12];
                o_range_err    = ~w_sext_20 | i_imm[0];
            end
            default: begin
                o_instr     = i_base;
                o_range_err = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// ============================================================================
// imm_encoder
// Streaming immediate encoder with run control, address generation and a
// one-deep valid/ready output register.
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_encoder
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            ImmSrc,
    input  logic [DATA_WIDTH-1:0] base_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  range_err,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  busy,
    output logic                  done
);

    enc_state_e             r_state;
    enc_state_e             w_state_next;
    logic [CNT_WIDTH-1:0]   r_remaining;
    logic [ADDR_WIDTH-1:0]  r_next_addr;
    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_instr;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic                   r_range_err;
    logic [CNT_WIDTH-1:0]   r_err_cnt;

    logic [DATA_WIDTH-1:0]  w_instr;
    logic                   w_range_err;
    logic                   w_start;
    logic                   w_in_ready;
    logic                   w_in_hs;
    logic                   w_out_hs;

    imm_field_pack u_pack (
        .i_imm_src   (ImmSrc),
        .i_base      (base_i),
        .i_imm       (imm_i),
        .o_instr     (w_instr),
        .o_range_err (w_range_err)
    );

    assign w_start    = (r_state == ST_IDLE) && start;
    assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
    assign w_in_hs    = in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (num_words == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_in_hs && (r_remaining == CNT_WIDTH'(1))) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_out_valid || out_ready) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_next_addr <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_remaining <= num_words;
                r_next_addr <= BASE_ADDR;
            end else if (w_in_hs) begin
                r_remaining <= r_remaining - CNT_WIDTH'(1);
                r_next_addr <= r_next_addr + ADDR_WIDTH'(4);
            end
            // Saturating count of flagged words that actually left the block.
            if (w_start) begin
                r_err_cnt <= '0;
            end else if (w_out_hs && r_range_err && !(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_instr     <= '0;
            r_addr      <= BASE_ADDR;
            r_range_err <= 1'b0;
        end else if (w_in_hs) begin
            r_out_valid <= 1'b1;
            r_instr     <= w_instr;
            r_addr      <= r_next_addr;
            r_range_err <= w_range_err;
        end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign instr_o   = r_instr;
    assign addr_o    = r_addr;
    assign range_err = r_range_err;
    assign err_cnt   = r_err_cnt;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ============================================================================
// tb_imm_encoder
// Scoreboard bench: driver pushes expected words, negedge monitor pops them.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imm_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_words;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ImmSrc;
    logic [31:0] base_i;
    logic [31:0] imm_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_o;
    logic [31:0] addr_o;
    logic        range_err;
    logic [15:0] err_cnt;
    logic        busy;
    logic        done;

    imm_encoder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (32'h0),
        .CNT_WIDTH  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ImmSrc    (ImmSrc),
        .base_i    (base_i),
        .imm_i     (imm_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_o   (instr_o),
        .addr_o    (addr_o),
        .range_err (range_err),
        .err_cnt   (err_cnt),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
        logic        rt;
        logic [2:0]  src;
        logic [31:0] imm;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_addr = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] decode(input logic [31:0] x, input logic [2:0] src);
        case (src)
            3'b000:  decode = {{20{x[31]}}, x[31:20]};
            3'b001:  decode = {x[31:12], 12'b0};
            3'b010:  decode = {{20{x[31]}}, x[31:25], x[11:7]};
            3'b011:  decode = {{19{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
            3'b100:  decode = {{11{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
            default: decode = 32'h0;
        endcase
    endfunction

    // Monitor: compare on each output handshake and check hold-while-stalled.
    logic        stall_prev = 1'b0;
    logic [31:0] hold_instr, hold_addr;
    logic        hold_err;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (stall_prev) begin
                chk("hold_instr", instr_o, hold_instr);
                chk("hold_addr", addr_o, hold_addr);
                chk("hold_err", {31'b0, range_err}, {31'b0, hold_err});
            end
            if (out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'h1, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("addr", addr_o, e.addr);
                    if (e.rt) begin
                        chk("rt_decode", decode(instr_o, e.src), e.imm);
                        chk("rt_err", {31'b0, range_err}, 32'h0);
                    end else begin
                        chk("instr", instr_o, e.instr);
                        chk("range_err", {31'b0, range_err}, {31'b0, e.err});
                    end
                end
            end
            stall_prev = !out_ready;
            hold_instr = instr_o;
            hold_addr  = addr_o;
            hold_err   = range_err;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic start_run(input logic [15:0] n);
        start     = 1'b1;
        num_words = n;
        exp_addr  = 32'h0;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send(input logic [2:0] src, input logic [31:0] base, input logic [31:0] imm,
                        input logic [31:0] exp_i, input logic exp_e, input logic rt);
        bit   got;
        exp_t e;
        ImmSrc   = src;
        base_i   = base;
        imm_i    = imm;
        in_valid = 1'b1;
        got      = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("send_timeout", 32'h1, 32'h0);
        end else begin
            e.instr = exp_i; e.addr = exp_addr; e.err = exp_e;
            e.rt = rt; e.src = src; e.imm = imm;
            sb.push_back(e);
            exp_addr = exp_addr + 32'd4;
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        in_valid = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", {31'b0, seen}, 32'h1);
        chk("sb_empty_at_done", sb.size(), 32'h0);
        @(negedge clk);
        chk("done_one_cycle", {31'b0, done}, 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; num_words = '0; in_valid = 1'b0;
        ImmSrc = '0; base_i = '0; imm_i = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_err_cnt", {16'b0, err_cnt}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors: format, template, immediate, expected word, expected flag.
        start_run(16'd16);
        send(3'b000, 32'h0000_0013, 32'hFFFF_FFFF, 32'hFFF0_0013, 1'b0, 1'b0);
        send(3'b011, 32'h0000_0063, 32'h0000_0800, 32'h0000_00E3, 1'b0, 1'b0);
        send(3'b011, 32'h0000_0063, 32'h0000_0003, 32'h0000_0163, 1'b1, 1'b0);
        send(3'b001, 32'h0000_0037, 32'h1234_5000, 32'h1234_5037, 1'b0, 1'b0);
        send(3'b001, 32'h0000_0037, 32'h1234_5678, 32'h1234_5037, 1'b1, 1'b0);
        send(3'b010, 32'h0000_0023, 32'hFFFF_FFFC, 32'hFE00_0E23, 1'b0, 1'b0);
        send(3'b010, 32'h0000_0023, 32'h0000_07FF, 32'h7E00_0FA3, 1'b0, 1'b0);
        send(3'b100, 32'h0000_006F, 32'h0000_0800, 32'h0010_006F, 1'b0, 1'b0);
        send(3'b100, 32'h0000_006F, 32'h0010_0000, 32'h8000_006F, 1'b1, 1'b0);
        send(3'b100, 32'h0000_006F, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0, 1'b0);
        send(3'b011, 32'h0000_0063, 32'hFFFF_FFFE, 32'hFE00_0FE3, 1'b0, 1'b0);
        send(3'b000, 32'h0000_0013, 32'h0000_0800, 32'h8000_0013, 1'b1, 1'b0);
        send(3'b000, 32'hFFF0_0013, 32'h0000_0000, 32'h0000_0013, 1'b0, 1'b0);
        send(3'b101, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b1, 1'b0);
        send(3'b110, 32'h0000_0033, 32'h0000_0010, 32'h0000_0033, 1'b1, 1'b0);
        send(3'b111, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1, 1'b0);
        wait_done();
        chk("err_cnt_directed", {16'b0, err_cnt}, 32'd7);

        // Four-word run with a 3-cycle stall on word 2; stray start ignored.
        start_run(16'd4);
        send(3'b000, 32'h13, 32'd1, 32'h0010_0013, 1'b0, 1'b0);
        send(3'b000, 32'h13, 32'd2, 32'h0020_0013, 1'b0, 1'b0);
        out_ready = 1'b0;
        start = 1'b1; num_words = 16'd0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, out_valid}, 32'h1);
            chk("stall_addr", addr_o, 32'h4);
            chk("stall_busy", {31'b0, busy}, 32'h1);
        end
        @(posedge clk); #1;
        start = 1'b0; out_ready = 1'b1;
        send(3'b000, 32'h13, 32'd3, 32'h0030_0013, 1'b0, 1'b0);
        send(3'b000, 32'h13, 32'd4, 32'h0040_0013, 1'b0, 1'b0);
        wait_done();
        chk("err_cnt_cleared", {16'b0, err_cnt}, 32'h0);

        // Zero-length run.
        start_run(16'd0);
        @(negedge clk);
        chk("zero_done", {31'b0, done}, 32'h1);
        chk("zero_in_ready", {31'b0, in_ready}, 32'h0);
        chk("zero_out_valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        chk("zero_done_clear", {31'b0, done}, 32'h0);
        chk("zero_busy", {31'b0, busy}, 32'h0);

        // Round-trip through an independent decoder for each format.
        for (int f = 0; f < 5; f++) begin
            start_run(16'd1000);
            for (int k = 0; k < 1000; k++) begin
                logic [31:0] r, imm;
                r = $urandom;
                case (f)
                    0, 2:    imm = {{20{r[11]}}, r[11:0]};
                    1:       imm = {r[31:12], 12'b0};
                    3:       imm = {{19{r[12]}}, r[12:1], 1'b0};
                    default: imm = {{11{r[20]}}, r[20:1], 1'b0};
                endcase
                send(3'(f), $urandom, imm, 32'h0, 1'b0, 1'b1);
            end
            wait_done();
            chk("rt_err_cnt", {16'b0, err_cnt}, 32'h0);
        end

        // Reset mid-run while a word is pending.
        start_run(16'd3);
        send(3'b000, 32'h13, 32'h0000_0800, 32'h8000_0013, 1'b1, 1'b0);
        send(3'b000, 32'h13, 32'd5, 32'h0050_0013, 1'b0, 1'b0);
        out_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", {31'b0, out_valid}, 32'h1);
        chk("pre_rst_err_cnt", {16'b0, err_cnt}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        sb.delete();
        @(negedge clk);
        chk("mrst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("mrst_in_ready", {31'b0, in_ready}, 32'h0);
        chk("mrst_busy", {31'b0, busy}, 32'h0);
        chk("mrst_done", {31'b0, done}, 32'h0);
        chk("mrst_instr", instr_o, 32'h0);
        chk("mrst_addr", addr_o, 32'h0);
        chk("mrst_range_err", {31'b0, range_err}, 32'h0);
        chk("mrst_err_cnt", {16'b0, err_cnt}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        start_run(16'd1);
        send(3'b001, 32'h37, 32'hABCD_E000, 32'hABCD_E037, 1'b0, 1'b0);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
